noc_exu_endpoint: RTL and testbench

- Parametrised NoC endpoint that connects any in-order execution unit (divider, multiplier, ...) to the EXU NoC.
- Deserialises multi-flit request packets into one wide request plus sideband.
- Tracks up to DEPTH outstanding operations and serialises each result back to the requester's source address.
- Generalises the fixed 32-bit serial receiver/sender pair: any payload width, response buffering, return-address routing, back-pressure on both sides.

---
 rtl/noc_exu_endpoint_if.sv | 51 +++++
 rtl/noc_exu_endpoint.sv | 267 ++++++++++++++++++++++++++
 tb/tb_noc_exu_endpoint.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/noc_exu_endpoint_if.sv
// -----------------------------------------------------------------------------
// noc_exu_endpoint_if
// Bundle of the handshake / data signals between an EXU NoC endpoint, the NoC
// and the execution unit it serves.
//   down_*   : NoC -> endpoint flit stream (valid/ready)
//   req_*    : endpoint -> unit assembled request (valid/ready)
//   rsp_*    : unit -> endpoint result pulse (no back-pressure)
//   up_*     : endpoint -> NoC flit stream (valid/ready)
//   rsp_err  : result arrived with nothing awaiting it
//   drop_err : packet discarded on destination mismatch
// Modports:
//   slave  : the endpoint's view
//   master : the environment's view (NoC + unit)
// -----------------------------------------------------------------------------
interface noc_exu_endpoint_if #(
    parameter int FLIT_BITS = 32,
    parameter int REQ_BITS  = 64,
    parameter int RSP_BITS  = 32,
    parameter int SIDE_BITS = 8
);
    logic                 down_valid;
    logic [FLIT_BITS-1:0] down_data;
    logic                 down_ready;

    logic                 req_valid;
    logic [REQ_BITS-1:0]  req_data;
    logic [SIDE_BITS-1:0] req_side;
    logic                 req_ready;

    logic                 rsp_valid;
    logic [RSP_BITS-1:0]  rsp_data;

    logic                 up_valid;
    logic [FLIT_BITS-1:0] up_data;
    logic                 up_ready;

    logic                 rsp_err;
    logic                 drop_err;

    modport slave (
        input  down_valid, down_data, req_ready, rsp_valid, rsp_data, up_ready,
        output down_ready, req_valid, req_data, req_side, up_valid, up_data,
               rsp_err, drop_err
    );

    modport master (
        output down_valid, down_data, req_ready, rsp_valid, rsp_data, up_ready,
        input  down_ready, req_valid, req_data, req_side, up_valid, up_data,
               rsp_err, drop_err
    );
endinterface

// File: rtl/noc_exu_endpoint.sv
// -----------------------------------------------------------------------------
// noc_exu_endpoint
// NoC endpoint for an in-order execution unit. Incoming multi-flit packets are
// deserialised into one wide request plus sideband; the requester's address is
// queued per issued op, and each unit result is serialised back to it.
//
// Ports:
//   clk    : NoC clock
//   rst_l  : asynchronous active-low reset
//   flush  : synchronous flush, highest priority, returns to reset state
//   bus    : noc_exu_endpoint_if.slave (down/req/rsp/up streams, error pulses)
//
// Optional feature (macro NOC_EP_DST_CHECK_EN):
//   defined   : headers with dst != MY_ADDR are consumed and dropped, drop_err
//               pulses once after the last payload flit
//   undefined : dst ignored, every packet issued, drop_err tied low
//
// Receive FSM
//   state   | meaning
//   RX_HDR  | waiting for header flit
//   RX_BODY | shifting in REQ_FLITS payload flits
//   RX_HOLD | request presented to unit (needs credit)
// Transmit FSM
//   state   | meaning
//   TX_IDLE | no queued result
//   TX_HDR  | header flit to source-FIFO head on up_data
//   TX_BODY | RSP_FLITS payload flits on up_data
// -----------------------------------------------------------------------------
module noc_exu_endpoint #(
    parameter int FLIT_BITS = 32,
    parameter int REQ_BITS  = 64,
    parameter int RSP_BITS  = 32,
    parameter int ADDR_BITS = 4,
    parameter int SIDE_BITS = 8,
    parameter int DEPTH     = 4,
    parameter int MY_ADDR   = 0
) (
    input logic                clk,
    input logic                rst_l,
    input logic                flush,
    noc_exu_endpoint_if.slave  bus
);
    localparam int REQ_FLITS = (REQ_BITS + FLIT_BITS - 1) / FLIT_BITS;
    localparam int RSP_FLITS = (RSP_BITS + FLIT_BITS - 1) / FLIT_BITS;
    localparam int REQ_PAD   = REQ_FLITS * FLIT_BITS;
    localparam int RSP_PAD   = RSP_FLITS * FLIT_BITS;
    localparam int RXB_W     = $clog2(REQ_FLITS + 1);
    localparam int TXB_W     = $clog2(RSP_FLITS + 1);
    localparam int PTR_W     = $clog2(DEPTH);
    localparam int CNT_W     = PTR_W + 1;

    localparam logic [RXB_W-1:0] RX_LAST = RXB_W'(REQ_FLITS - 1);
    localparam logic [TXB_W-1:0] TX_LAST = TXB_W'(RSP_FLITS - 1);

    localparam logic [1:0] RX_HDR  = 2'd0;
    localparam logic [1:0] RX_BODY = 2'd1;
    localparam logic [1:0] RX_HOLD = 2'd2;

    localparam logic [1:0] TX_IDLE = 2'd0;
    localparam logic [1:0] TX_HDR  = 2'd1;
    localparam logic [1:0] TX_BODY = 2'd2;

    logic [1:0]           rx_state_q, rx_state_d;
    logic [RXB_W-1:0]     rx_beat_q, rx_beat_d;
    logic [ADDR_BITS-1:0] src_q, src_d;
    logic [SIDE_BITS-1:0] side_q, side_d;
    logic                 drop_q, drop_d;
    logic [REQ_PAD-1:0]   shreg_q, shreg_d;

    logic [1:0]           tx_state_q, tx_state_d;
    logic [TXB_W-1:0]     tx_beat_q, tx_beat_d;

    logic [ADDR_BITS-1:0] sf_mem [DEPTH];
    logic [RSP_BITS-1:0]  rf_mem [DEPTH];
    logic [PTR_W-1:0]     sf_wr_q, sf_rd_q, rf_wr_q, rf_rd_q;
    logic [CNT_W-1:0]     sf_cnt_q, sf_cnt_d;
    logic [CNT_W-1:0]     rf_cnt_q, rf_cnt_d;
    logic                 rsp_err_q;

    logic                 down_ready, req_valid, up_valid;
    logic                 rx_xfer, rx_last, issue, up_xfer, tx_last;
    logic                 res_push, rsp_err_d, hdr_drop;
    logic [CNT_W-1:0]     awaiting;
    logic [RSP_PAD-1:0]   rsp_pad;
    logic [FLIT_BITS-1:0] up_data_c;

    // Held low during reset so every output reads 0 while rst_l is asserted.
    assign down_ready = rst_l && (rx_state_q != RX_HOLD);
    // Source-FIFO occupancy doubles as the outstanding-operation counter.
    assign req_valid  = (rx_state_q == RX_HOLD) && (sf_cnt_q < CNT_W'(DEPTH));
    assign up_valid   = (tx_state_q != TX_IDLE);

    assign rx_xfer  = bus.down_valid && down_ready;
    assign rx_last  = rx_xfer && (rx_state_q == RX_BODY) && (rx_beat_q == RX_LAST);
    assign issue    = req_valid && bus.req_ready;
    assign up_xfer  = up_valid && bus.up_ready;
    assign tx_last  = up_xfer && (tx_state_q == TX_BODY) && (tx_beat_q == TX_LAST);

    assign awaiting  = sf_cnt_q - rf_cnt_q;
    assign res_push  = bus.rsp_valid && (awaiting != '0) && !flush;
    assign rsp_err_d = bus.rsp_valid && (awaiting == '0) && !flush;

    assign sf_cnt_d = sf_cnt_q + CNT_W'(issue) - CNT_W'(tx_last);
    assign rf_cnt_d = rf_cnt_q + CNT_W'(res_push) - CNT_W'(tx_last);

`ifdef NOC_EP_DST_CHECK_EN
    assign hdr_drop = (bus.down_data[ADDR_BITS-1:0] != ADDR_BITS'(MY_ADDR));
`else
    assign hdr_drop = 1'b0;
`endif

    always_comb begin
        rx_state_d = rx_state_q;
        rx_beat_d  = rx_beat_q;
        src_d      = src_q;
        side_d     = side_q;
        drop_d     = drop_q;
        shreg_d    = shreg_q;
        case (rx_state_q)
            RX_HDR: begin
                if (rx_xfer) begin
                    src_d      = bus.down_data[2*ADDR_BITS-1:ADDR_BITS];
                    side_d     = bus.down_data[2*ADDR_BITS+SIDE_BITS-1:2*ADDR_BITS];
                    drop_d     = hdr_drop;
                    rx_beat_d  = '0;
                    rx_state_d = RX_BODY;
                end
            end
            RX_BODY: begin
                if (rx_xfer) begin
                    // Least-significant chunk arrives first: shift in from the top.
                    shreg_d = REQ_PAD'({bus.down_data, shreg_q} >> FLIT_BITS);
                    if (rx_beat_q == RX_LAST) begin
                        rx_beat_d  = '0;
                        rx_state_d = drop_q ? RX_HDR : RX_HOLD;
                    end else begin
                        rx_beat_d = rx_beat_q + 1'b1;
                    end
                end
            end
            RX_HOLD: begin
                if (issue) rx_state_d = RX_HDR;
            end
            default: rx_state_d = RX_HDR;
        endcase
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_beat_d  = tx_beat_q;
        case (tx_state_q)
            TX_IDLE: begin
                // Looking at the post-push count lets up_valid rise right after the push.
                if (rf_cnt_d != '0) tx_state_d = TX_HDR;
            end
            TX_HDR: begin
                if (up_xfer) begin
                    tx_beat_d  = '0;
                    tx_state_d = TX_BODY;
                end
            end
            TX_BODY: begin
                if (up_xfer) begin
                    if (tx_beat_q == TX_LAST) begin
                        tx_beat_d  = '0;
                        tx_state_d = (rf_cnt_d != '0) ? TX_HDR : TX_IDLE;
                    end else begin
                        tx_beat_d = tx_beat_q + 1'b1;
                    end
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    assign rsp_pad = RSP_PAD'(rf_mem[rf_rd_q]);

    always_comb begin
        up_data_c = '0;
        case (tx_state_q)
            TX_HDR: begin
                up_data_c[ADDR_BITS-1:0]           = sf_mem[sf_rd_q];
                up_data_c[2*ADDR_BITS-1:ADDR_BITS] = ADDR_BITS'(MY_ADDR);
            end
            TX_BODY: up_data_c = FLIT_BITS'(rsp_pad >> (int'(tx_beat_q) * FLIT_BITS));
            default: up_data_c = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            rx_state_q <= RX_HDR;
            rx_beat_q  <= '0;
            src_q      <= '0;
            side_q     <= '0;
            drop_q     <= 1'b0;
            shreg_q    <= '0;
            tx_state_q <= TX_IDLE;
            tx_beat_q  <= '0;
            sf_wr_q    <= '0;
            sf_rd_q    <= '0;
            rf_wr_q    <= '0;
            rf_rd_q    <= '0;
            sf_cnt_q   <= '0;
            rf_cnt_q   <= '0;
            rsp_err_q  <= 1'b0;
        end else if (flush) begin
            rx_state_q <= RX_HDR;
            rx_beat_q  <= '0;
            src_q      <= '0;
            side_q     <= '0;
            drop_q     <= 1'b0;
            shreg_q    <= '0;
            tx_state_q <= TX_IDLE;
            tx_beat_q  <= '0;
            sf_wr_q    <= '0;
            sf_rd_q    <= '0;
            rf_wr_q    <= '0;
            rf_rd_q    <= '0;
            sf_cnt_q   <= '0;
            rf_cnt_q   <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_beat_q  <= rx_beat_d;
            src_q      <= src_d;
            side_q     <= side_d;
            drop_q     <= drop_d;
            shreg_q    <= shreg_d;
            tx_state_q <= tx_state_d;
            tx_beat_q  <= tx_beat_d;
            sf_wr_q    <= sf_wr_q + PTR_W'(issue);
            sf_rd_q    <= sf_rd_q + PTR_W'(tx_last);
            rf_wr_q    <= rf_wr_q + PTR_W'(res_push);
            rf_rd_q    <= rf_rd_q + PTR_W'(tx_last);
            sf_cnt_q   <= sf_cnt_d;
            rf_cnt_q   <= rf_cnt_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    // FIFO storage needs no reset; occupancy is tracked by the counters above.
    always_ff @(posedge clk) begin
        if (issue && !flush) sf_mem[sf_wr_q] <= src_q;
        if (res_push)        rf_mem[rf_wr_q] <= bus.rsp_data;
    end

`ifdef NOC_EP_DST_CHECK_EN
    logic drop_err_q;
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l)     drop_err_q <= 1'b0;
        else if (flush) drop_err_q <= 1'b0;
        else            drop_err_q <= rx_last && drop_q;
    end
    assign bus.drop_err = drop_err_q;
`else
    assign bus.drop_err = 1'b0;
`endif

    assign bus.down_ready = down_ready;
    assign bus.req_valid  = req_valid;
    assign bus.req_data   = REQ_BITS'(shreg_q);
    assign bus.req_side   = side_q;
    assign bus.up_valid   = up_valid;
    assign bus.up_data    = up_data_c;
    assign bus.rsp_err    = rsp_err_q;
endmodule

// File: tb/tb_noc_exu_endpoint.sv
module tb_noc_exu_endpoint;
    localparam int FLIT_BITS = 32;
    localparam int REQ_BITS  = 64;
    localparam int RSP_BITS  = 32;
    localparam int ADDR_BITS = 4;
    localparam int SIDE_BITS = 8;
    localparam int DEPTH     = 2;
    localparam int MY_ADDR   = 3;

    logic clk = 1'b0;
    logic rst_l;
    logic flush;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    noc_exu_endpoint_if #(
        .FLIT_BITS(FLIT_BITS), .REQ_BITS(REQ_BITS),
        .RSP_BITS(RSP_BITS), .SIDE_BITS(SIDE_BITS)
    ) bus ();

    noc_exu_endpoint #(
        .FLIT_BITS(FLIT_BITS), .REQ_BITS(REQ_BITS), .RSP_BITS(RSP_BITS),
        .ADDR_BITS(ADDR_BITS), .SIDE_BITS(SIDE_BITS), .DEPTH(DEPTH),
        .MY_ADDR(MY_ADDR)
    ) dut (
        .clk   (clk),
        .rst_l (rst_l),
        .flush (flush),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_flit(input logic [31:0] d);
        int w;
        w = 0;
        bus.down_valid = 1'b1;
        bus.down_data  = d;
        while (!bus.down_ready && w < 50) begin
            tick();
            w++;
        end
        n_cmp++;
        assert (w < 50) else begin
            n_err++;
            $error("FAIL down_ready_timeout: observed waited %0d expected < 50", w);
        end
        tick();
        bus.down_valid = 1'b0;
        bus.down_data  = '0;
    endtask

    task automatic pulse_rsp(input logic [31:0] d);
        bus.rsp_valid = 1'b1;
        bus.rsp_data  = d;
        tick();
        bus.rsp_valid = 1'b0;
        bus.rsp_data  = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_l          = 1'b0;
        flush          = 1'b0;
        bus.down_valid = 1'b0;
        bus.down_data  = '0;
        bus.req_ready  = 1'b0;
        bus.rsp_valid  = 1'b0;
        bus.rsp_data   = '0;
        bus.up_ready   = 1'b0;
        repeat (3) tick();

        // Reset state
        chk("rst_down_ready", bus.down_ready, 0);
        chk("rst_req_valid",  bus.req_valid,  0);
        chk("rst_req_data",   bus.req_data,   0);
        chk("rst_up_valid",   bus.up_valid,   0);
        chk("rst_up_data",    bus.up_data,    0);
        chk("rst_rsp_err",    bus.rsp_err,    0);
        chk("rst_drop_err",   bus.drop_err,   0);
        @(negedge clk);
        rst_l = 1'b1;
        tick();
        chk("post_rst_down_ready", bus.down_ready, 1);

        // Single op
        bus.req_ready = 1'b1;
        send_flit(32'h0000_A553);
        send_flit(32'h1111_1111);
        send_flit(32'h2222_2222);
        chk("s_req_valid",  bus.req_valid,  1);
        chk("s_req_data",   bus.req_data,   64'h2222_2222_1111_1111);
        chk("s_req_side",   bus.req_side,   8'hA5);
        chk("s_down_ready", bus.down_ready, 0);
        tick();
        chk("s_req_valid_drop", bus.req_valid, 0);
        chk("s_down_ready_back", bus.down_ready, 1);
        pulse_rsp(32'hDEAD_BEEF);
        chk("s_up_valid_hdr", bus.up_valid, 1);
        chk("s_up_hdr",       bus.up_data,  32'h0000_0035);
        bus.up_ready = 1'b1;
        tick();
        chk("s_up_body",      bus.up_data,  32'hDEAD_BEEF);
        tick();
        chk("s_up_idle",      bus.up_valid, 0);
        chk("s_rsp_err",      bus.rsp_err,  0);
        bus.up_ready = 1'b0;

        // Spurious result
        pulse_rsp(32'h0BAD_0BAD);
        chk("sp_rsp_err",  bus.rsp_err,  1);
        chk("sp_up_valid", bus.up_valid, 0);
        tick();
        chk("sp_rsp_err_end", bus.rsp_err,  0);
        chk("sp_up_valid2",   bus.up_valid, 0);

        // Credit stall with back-pressure on the first response
        send_flit(32'h0000_0013);
        send_flit(32'h0000_0101);
        send_flit(32'h0000_0102);
        send_flit(32'h0000_0023);
        send_flit(32'h0000_0201);
        send_flit(32'h0000_0202);
        send_flit(32'h0000_0043);
        send_flit(32'h0000_0401);
        send_flit(32'h0000_0402);
        chk("c_req_valid_stall",  bus.req_valid,  0);
        chk("c_down_ready_stall", bus.down_ready, 0);
        repeat (3) tick();
        chk("c_req_valid_stall2", bus.req_valid,  0);
        chk("c_up_valid_none",    bus.up_valid,   0);
        pulse_rsp(32'hAAAA_0001);
        chk("c_hdr1",      bus.up_data,   32'h0000_0031);
        chk("c_req_still", bus.req_valid, 0);
        bus.up_ready = 1'b1;
        tick();
        bus.up_ready = 1'b0;
        chk("c_body1", bus.up_data, 32'hAAAA_0001);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_up_valid", bus.up_valid, 1);
            chk("bp_up_data",  bus.up_data,  32'hAAAA_0001);
        end
        bus.up_ready = 1'b1;
        tick();
        bus.up_ready = 1'b0;
        chk("c_up_idle1",  bus.up_valid,  0);
        chk("c_req_issue", bus.req_valid, 1);
        chk("c_req_data3", bus.req_data,  64'h0000_0402_0000_0401);
        tick();
        chk("c_req_done",  bus.req_valid, 0);
        bus.rsp_valid = 1'b1;
        bus.rsp_data  = 32'hBBBB_0002;
        tick();
        chk("c_hdr2", bus.up_data, 32'h0000_0032);
        bus.rsp_data  = 32'hCCCC_0003;
        tick();
        bus.rsp_valid = 1'b0;
        bus.rsp_data  = '0;
        chk("c_hdr2_held", bus.up_data, 32'h0000_0032);
        bus.up_ready = 1'b1;
        tick();
        chk("c_body2", bus.up_data, 32'hBBBB_0002);
        tick();
        chk("c_hdr3_valid", bus.up_valid, 1);
        chk("c_hdr3", bus.up_data, 32'h0000_0034);
        tick();
        chk("c_body3", bus.up_data, 32'hCCCC_0003);
        tick();
        chk("c_up_idle3", bus.up_valid, 0);
        chk("c_rsp_err",  bus.rsp_err,  0);
        bus.up_ready = 1'b0;

        // Flush mid-packet with one op outstanding
        send_flit(32'h0000_0063);
        send_flit(32'h6666_6666);
        send_flit(32'h7777_7777);
        chk("f_req_valid_a", bus.req_valid, 1);
        tick();
        send_flit(32'h0000_5A63);
        send_flit(32'h3333_3333);
        flush         = 1'b1;
        bus.rsp_valid = 1'b1;
        bus.rsp_data  = 32'h0000_0099;
        tick();
        flush         = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.rsp_data  = '0;
        chk("f_rsp_err",    bus.rsp_err,    0);
        chk("f_up_valid",   bus.up_valid,   0);
        chk("f_down_ready", bus.down_ready, 1);
        chk("f_req_valid",  bus.req_valid,  0);
        tick();
        chk("f_up_valid2",  bus.up_valid,   0);
        pulse_rsp(32'h0000_0077);
        chk("f_outst_zero_err", bus.rsp_err,  1);
        chk("f_outst_zero_up",  bus.up_valid, 0);
        send_flit(32'h0000_C593);
        send_flit(32'h4444_4444);
        send_flit(32'h5555_5555);
        chk("f_req_valid_b", bus.req_valid, 1);
        chk("f_req_data_b",  bus.req_data,  64'h5555_5555_4444_4444);
        chk("f_req_side_b",  bus.req_side,  8'hC5);
        tick();
        pulse_rsp(32'h1234_5678);
        chk("f_hdr", bus.up_data, 32'h0000_0039);
        bus.up_ready = 1'b1;
        tick();
        chk("f_body", bus.up_data, 32'h1234_5678);
        tick();
        chk("f_idle", bus.up_valid, 0);
        bus.up_ready = 1'b0;

        // Destination mismatch (dst 7)
        send_flit(32'h0000_0017);
        send_flit(32'h8888_8888);
        send_flit(32'h9999_9999);
`ifdef NOC_EP_DST_CHECK_EN
        chk("d_drop_err",   bus.drop_err,   1);
        chk("d_req_valid",  bus.req_valid,  0);
        chk("d_down_ready", bus.down_ready, 1);
        tick();
        chk("d_drop_err_end", bus.drop_err,  0);
        chk("d_req_valid2",   bus.req_valid, 0);
`else
        chk("d_drop_err",  bus.drop_err,  0);
        chk("d_req_valid", bus.req_valid, 1);
        chk("d_req_data",  bus.req_data,  64'h9999_9999_8888_8888);
        tick();
        chk("d_req_done",  bus.req_valid, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
